// File: rtl/dma_bus_ctrl_if.sv
// Bus-side handshake bundle for dma_bus_ctrl.
// master: the controller. slave: the DMA engine / CPU side.
interface dma_bus_ctrl_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              begin_dma;
  logic [ADDR_W-1:0] target_address;
  logic [LEN_W-1:0]  length;
  logic [CH_W-1:0]   dma_ch;
  logic              bg;
  logic              busy;
  logic              br;
  logic              dma_end;
  logic              cpu_busy;

  modport master (
    output begin_dma, target_address, length, dma_ch, bg, busy,
    input  br, dma_end, cpu_busy
  );

  modport slave (
    input  begin_dma, target_address, length, dma_ch, bg, busy,
    output br, dma_end, cpu_busy
  );
endinterface

// File: rtl/dma_bus_ctrl.sv
// dma_bus_ctrl: per-channel IRQ latching, round-robin dispatch of a one-cycle
// begin_dma command, br/bg bus handoff against CPU activity, retirement on dma_end.
// Optional sticky completion flags (done_irq/irq_clr) when DMA_DONE_IRQ_EN is defined.
module dma_bus_ctrl #(
  parameter int unsigned       NUM_CH   = 2,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       LEN_W    = 16,
  parameter logic [ADDR_W-1:0] DEF_ADDR = 16'h000b,
  parameter logic [LEN_W-1:0]  DEF_LEN  = 16'd12,
  localparam int unsigned      CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_sel,
  input  logic [ADDR_W-1:0] cfg_wdata,
  input  logic [NUM_CH-1:0] irq_in,
  output logic [NUM_CH-1:0] ch_pending,
`ifdef DMA_DONE_IRQ_EN
  output logic [NUM_CH-1:0] done_irq,
  input  logic [NUM_CH-1:0] irq_clr,
`endif
  dma_bus_ctrl_if.master    bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CMD     = 3'd1;
  localparam logic [2:0] WAIT_BR = 3'd2;
  localparam logic [2:0] GRANT   = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]        state;
  logic [CH_W-1:0]   rr;
  logic [NUM_CH-1:0] irq_prev;
  logic [NUM_CH-1:0] irq_edge;
  logic [NUM_CH-1:0] retire_mask;
  logic [ADDR_W-1:0] addr_reg [NUM_CH];
  logic [LEN_W-1:0]  len_reg  [NUM_CH];
  logic [LEN_W-1:0]  cfg_len;
  logic [ADDR_W-1:0] tgt_q;
  logic [LEN_W-1:0]  len_q;
  logic [CH_W-1:0]   ch_q;
  logic              bg_q;
  logic              pick_found;
  logic [CH_W-1:0]   pick_ch;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    if (32'(c) >= NUM_CH - 1) return '0;
    return c + 1'b1;
  endfunction

  assign irq_edge = irq_in & ~irq_prev;
  assign cfg_len  = LEN_W'(cfg_wdata);

  assign bus.begin_dma      = (state == CMD);
  assign bus.busy           = (state != IDLE);
  assign bus.bg             = bg_q;
  assign bus.target_address = tgt_q;
  assign bus.length         = len_q;
  assign bus.dma_ch         = ch_q;

  // Round-robin pick: first pending channel at or after rr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!pick_found && ch_pending[CH_W'((32'(rr) + i) % NUM_CH)]) begin
        pick_found = 1'b1;
        pick_ch    = CH_W'((32'(rr) + i) % NUM_CH);
      end
    end
  end

  // Channel retired this cycle: zero-length dispatch in IDLE, or normal completion in DONE.
  always_comb begin
    retire_mask = '0;
    if (state == IDLE && pick_found && len_reg[pick_ch] == '0)
      retire_mask[pick_ch] = 1'b1;
    else if (state == DONE)
      retire_mask[ch_q] = 1'b1;
  end

  // Config registers, pending/done flags and the dispatch/bus-handoff FSM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr         <= '0;
      irq_prev   <= '0;
      ch_pending <= '0;
      tgt_q      <= '0;
      len_q      <= '0;
      ch_q       <= '0;
      bg_q       <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        addr_reg[i] <= DEF_ADDR;
        len_reg[i]  <= DEF_LEN;
      end
`ifdef DMA_DONE_IRQ_EN
      done_irq   <= '0;
`endif
    end else begin
      irq_prev <= irq_in;

      if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
        if (cfg_sel) len_reg[cfg_ch]  <= cfg_len;
        else         addr_reg[cfg_ch] <= cfg_wdata;
      end

      // A fresh edge on the channel being retired re-arms it (set wins).
      ch_pending <= (ch_pending & ~retire_mask) | irq_edge;
`ifdef DMA_DONE_IRQ_EN
      done_irq   <= (done_irq & ~irq_clr) | retire_mask;
`endif

      case (state)
        IDLE: begin
          if (pick_found) begin
            ch_q  <= pick_ch;
            tgt_q <= addr_reg[pick_ch];
            len_q <= len_reg[pick_ch];
            if (len_reg[pick_ch] != '0) state <= CMD;
            else                        rr    <= next_ch(pick_ch);
          end
        end
        CMD: state <= WAIT_BR;
        WAIT_BR: begin
          if (bus.dma_end) begin
            state <= DONE;
          end else if (bus.br && !bus.cpu_busy) begin
            bg_q  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (bus.dma_end) begin
            bg_q  <= 1'b0;
            state <= DONE;
          end else if (!bus.br) begin
            bg_q  <= 1'b0;
            state <= WAIT_BR;
          end
        end
        DONE: begin
          bg_q  <= 1'b0;
          rr    <= next_ch(ch_q);
          state <= IDLE;
        end
        default: begin
          bg_q  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_bus_ctrl.sv
// Self-checking bench for dma_bus_ctrl (NUM_CH=2). Expected dispatches are queued
// when IRQs are raised and compared when begin_dma appears.
module tb_dma_bus_ctrl;

  logic        clk;
  logic        reset_n;
  logic        cfg_we;
  logic [0:0]  cfg_ch;
  logic        cfg_sel;
  logic [15:0] cfg_wdata;
  logic [1:0]  irq_in;
  logic [1:0]  ch_pending;
`ifdef DMA_DONE_IRQ_EN
  logic [1:0]  done_irq;
  logic [1:0]  irq_clr;
`endif

  dma_bus_ctrl_if #(.NUM_CH(2), .ADDR_W(16), .LEN_W(16)) bus_if ();

  dma_bus_ctrl #(
    .NUM_CH  (2),
    .ADDR_W  (16),
    .LEN_W   (16),
    .DEF_ADDR(16'h000b),
    .DEF_LEN (16'd12)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_sel   (cfg_sel),
    .cfg_wdata (cfg_wdata),
    .irq_in    (irq_in),
    .ch_pending(ch_pending),
`ifdef DMA_DONE_IRQ_EN
    .done_irq  (done_irq),
    .irq_clr   (irq_clr),
`endif
    .bus       (bus_if.master)
  );

  typedef struct {
    int          ch;
    logic [15:0] addr;
    logic [15:0] len;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_rr;
  logic [15:0] m_addr [2];
  logic [15:0] m_len  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_rr = 0;
    for (int k = 0; k < 2; k++) begin
      m_addr[k] = 16'h000b;
      m_len[k]  = 16'd12;
    end
  endtask

  task automatic cfg_write(input int ch, input logic sel, input logic [15:0] d);
    cfg_we    = 1'b1;
    cfg_ch    = 1'(ch);
    cfg_sel   = sel;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
    if (sel) m_len[ch] = d;
    else     m_addr[ch] = d;
  endtask

  // Queue expected dispatches in round-robin order from the model pointer.
  task automatic raise(input logic [1:0] mask);
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      int c;
      c = (m_rr + k) % 2;
      if (mask[c] && m_len[c] != 16'd0) begin
        e.ch   = c;
        e.addr = m_addr[c];
        e.len  = m_len[c];
        sb.push_back(e);
      end
    end
    irq_in = irq_in | mask;
  endtask

  task automatic wait_begin();
    int n;
    n = 0;
    while (bus_if.begin_dma !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("begin_seen", 32'(bus_if.begin_dma), 1);
  endtask

  // Entered in the begin_dma cycle; completes a simple br/bg/dma_end transfer.
  task automatic run_transfer();
    tick();
    check("begin_one_cycle", 32'(bus_if.begin_dma), 0);
    check("busy_wait_br", 32'(bus_if.busy), 1);
    bus_if.br = 1'b1;
    tick();
    check("bg_grant", 32'(bus_if.bg), 1);
    bus_if.dma_end = 1'b1;
    tick();
    bus_if.dma_end = 1'b0;
    bus_if.br      = 1'b0;
    check("bg_drop_done", 32'(bus_if.bg), 0);
    tick();
    check("busy_idle", 32'(bus_if.busy), 0);
  endtask

  // Scoreboard compare at every begin_dma pulse.
  always @(negedge clk) begin
    if (bus_if.begin_dma === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_begin", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("disp_ch", 32'(bus_if.dma_ch), 32'(mon_e.ch));
        check("disp_addr", 32'(bus_if.target_address), 32'(mon_e.addr));
        check("disp_len", 32'(bus_if.length), 32'(mon_e.len));
        m_rr = (mon_e.ch + 1) % 2;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n          = 1'b0;
    cfg_we           = 1'b0;
    cfg_ch           = '0;
    cfg_sel          = 1'b0;
    cfg_wdata        = '0;
    irq_in           = '0;
    bus_if.br        = 1'b0;
    bus_if.dma_end   = 1'b0;
    bus_if.cpu_busy  = 1'b0;
`ifdef DMA_DONE_IRQ_EN
    irq_clr          = '0;
`endif
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;

    check("rst_begin", 32'(bus_if.begin_dma), 0);
    check("rst_bg", 32'(bus_if.bg), 0);
    check("rst_busy", 32'(bus_if.busy), 0);
    check("rst_pending", 32'(ch_pending), 0);
    check("rst_addr", 32'(bus_if.target_address), 0);
    check("rst_len", 32'(bus_if.length), 0);
    check("rst_ch", 32'(bus_if.dma_ch), 0);

    // Default-register dispatch on ch0 with latency checks.
    raise(2'b01);
    tick();
    check("pend_lat", 32'(ch_pending), 32'h1);
    check("no_begin_yet", 32'(bus_if.begin_dma), 0);
    tick();
    check("begin_lat", 32'(bus_if.begin_dma), 1);
    irq_in = '0;
    run_transfer();
    check("pend_cleared", 32'(ch_pending), 0);

    // Programmed registers on ch1.
    cfg_write(1, 1'b0, 16'h0040);
    cfg_write(1, 1'b1, 16'd4);
    raise(2'b10);
    wait_begin();
    irq_in = '0;
    run_transfer();

    // Simultaneous IRQs with rr=0, then again with rr=1.
    raise(2'b11);
    wait_begin();
    irq_in = '0;
    run_transfer();
    tick();
    check("rr_back2back", 32'(bus_if.begin_dma), 1);
    run_transfer();
    raise(2'b01);
    wait_begin();
    irq_in = '0;
    run_transfer();
    raise(2'b11);
    wait_begin();
    irq_in = '0;
    run_transfer();
    tick();
    check("rr1_back2back", 32'(bus_if.begin_dma), 1);
    run_transfer();

    // Grant held off by CPU activity; br drop and re-request.
    raise(2'b01);
    wait_begin();
    irq_in = '0;
    tick();
    bus_if.cpu_busy = 1'b1;
    bus_if.br       = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bg_stall", 32'(bus_if.bg), 0);
    end
    bus_if.cpu_busy = 1'b0;
    tick();
    check("bg_after_stall", 32'(bus_if.bg), 1);
    bus_if.br = 1'b0;
    tick();
    check("bg_br_drop", 32'(bus_if.bg), 0);
    check("busy_br_drop", 32'(bus_if.busy), 1);
    bus_if.br = 1'b1;
    tick();
    check("bg_rerequest", 32'(bus_if.bg), 1);
    bus_if.dma_end = 1'b1;
    tick();
    bus_if.dma_end = 1'b0;
    bus_if.br      = 1'b0;
    check("bg_end_stall", 32'(bus_if.bg), 0);
    tick();
    check("busy_end_stall", 32'(bus_if.busy), 0);

    // Engine completes without ever taking the bus.
    raise(2'b10);
    wait_begin();
    irq_in = '0;
    tick();
    bus_if.dma_end = 1'b1;
    tick();
    bus_if.dma_end = 1'b0;
    check("nobus_bg", 32'(bus_if.bg), 0);
    check("nobus_busy_done", 32'(bus_if.busy), 1);
    tick();
    check("nobus_busy_idle", 32'(bus_if.busy), 0);
    check("nobus_pending", 32'(ch_pending), 0);

    // Zero-length retirement on ch0 (no begin_dma).
    cfg_write(0, 1'b1, 16'd0);
    raise(2'b01);
    tick();
    check("zl_pending_set", 32'(ch_pending), 32'h1);
    tick();
    check("zl_pending_clr", 32'(ch_pending), 0);
    check("zl_busy", 32'(bus_if.busy), 0);
    check("zl_no_begin", 32'(bus_if.begin_dma), 0);
    m_rr = 1;
    irq_in = '0;
`ifdef DMA_DONE_IRQ_EN
    check("done_sticky", 32'(done_irq), 32'h3);
    irq_clr = 2'b01;
    tick();
    irq_clr = '0;
    check("done_clr0", 32'(done_irq), 32'h2);
`endif

    // Reset in the middle of a granted transfer.
    raise(2'b10);
    wait_begin();
    irq_in = '0;
    tick();
    bus_if.br = 1'b1;
    tick();
    check("pre_rst_bg", 32'(bus_if.bg), 1);
    irq_in = 2'b01;
    tick();
    check("pre_rst_pending", 32'(ch_pending), 32'h3);
    reset_n = 1'b0;
    tick();
    check("mid_rst_bg", 32'(bus_if.bg), 0);
    check("mid_rst_busy", 32'(bus_if.busy), 0);
    check("mid_rst_pending", 32'(ch_pending), 0);
    check("mid_rst_addr", 32'(bus_if.target_address), 0);
    check("mid_rst_len", 32'(bus_if.length), 0);
    check("mid_rst_ch", 32'(bus_if.dma_ch), 0);
`ifdef DMA_DONE_IRQ_EN
    check("mid_rst_done", 32'(done_irq), 0);
`endif
    reset_n   = 1'b1;
    irq_in    = '0;
    bus_if.br = 1'b0;
    model_reset();
    tick();
    raise(2'b01);
    wait_begin();
    irq_in = '0;
    run_transfer();
    raise(2'b10);
    wait_begin();
    irq_in = '0;
    run_transfer();

    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
